// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
//   Shared definitions for the SDRAM sub-controllers. It holds the 5-bit
//   command encodings {CKE,CS_N,RAS_N,CAS_N,WE_N}, the auto-refresh FSM state
//   type, the address bit that selects precharge-all, and a small helper
//   used to size wait counters.
// ---------------------------------------------------------------------------
package sdram_pkg;

  localparam int CMD_W = 5;

  // Command bus encodings {CKE, CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [CMD_W-1:0] NOP  = 5'b10111;
  localparam logic [CMD_W-1:0] PREC = 5'b10010;
  localparam logic [CMD_W-1:0] AREF = 5'b10001;
  localparam logic [CMD_W-1:0] ACT  = 5'b10011;
  localparam logic [CMD_W-1:0] RD   = 5'b10101;
  localparam logic [CMD_W-1:0] WR   = 5'b10100;
  localparam logic [CMD_W-1:0] MRS  = 5'b10000;

  // A10 high during PRECHARGE means "all banks"
  localparam int A10_BIT = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECH,
    ST_WAIT_RP,
    ST_REF,
    ST_WAIT_RFC,
    ST_DONE
  } aref_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_aref_ctrl_if.sv
// ---------------------------------------------------------------------------
// sdram_aref_ctrl_if
//   Bundle between the auto-refresh controller and the SDRAM arbiter.
//   Signals:
//     aref_req    controller -> arbiter  level request, high while debt > 0
//     aref_en     arbiter -> controller  grant
//     aref_ack    controller -> arbiter  one-cycle completion pulse
//     aref_cmd    controller -> arbiter  5-bit command {CKE,CS_N,RAS_N,CAS_N,WE_N}
//     aref_addr   controller -> arbiter  address bus
//     aref_debt   controller -> arbiter  pending refresh count
//     aref_ovf    controller -> arbiter  sticky debt-overflow flag
//     aref_urgent controller -> arbiter  debt near saturation
//                                        (only with SDRAM_AREF_URGENT_EN)
//   Modports: master = refresh controller side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface sdram_aref_ctrl_if
  import sdram_pkg::*;
#(
  parameter int ADDR_W   = 12,
  parameter int MAX_DEBT = 8
);

  localparam int DEBT_W = $clog2(MAX_DEBT + 1);

  logic              aref_req;
  logic              aref_en;
  logic              aref_ack;
  logic [CMD_W-1:0]  aref_cmd;
  logic [ADDR_W-1:0] aref_addr;
  logic [DEBT_W-1:0] aref_debt;
  logic              aref_ovf;
`ifdef SDRAM_AREF_URGENT_EN
  logic              aref_urgent;

  modport master (
    input  aref_en,
    output aref_req, aref_ack, aref_cmd, aref_addr, aref_debt, aref_ovf,
    output aref_urgent
  );

  modport slave (
    output aref_en,
    input  aref_req, aref_ack, aref_cmd, aref_addr, aref_debt, aref_ovf,
    input  aref_urgent
  );
`else
  modport master (
    input  aref_en,
    output aref_req, aref_ack, aref_cmd, aref_addr, aref_debt, aref_ovf
  );

  modport slave (
    output aref_en,
    input  aref_req, aref_ack, aref_cmd, aref_addr, aref_debt, aref_ovf
  );
`endif

endinterface

// File: rtl/sdram_aref_timer.sv
// ---------------------------------------------------------------------------
// sdram_aref_timer
//   Refresh interval counter. Counts 0..REF_INTERVAL-1 while flag_init_i is
//   high and holds its value otherwise; tick_o is high for the one cycle the
//   count sits at its terminal value, after which it wraps to 0.
//   Ports:
//     clk_i        system clock
//     rst_i        synchronous reset, active-high
//     flag_init_i  SDRAM initialisation complete (count enable)
//     tick_o       one refresh interval has elapsed
// ---------------------------------------------------------------------------
module sdram_aref_timer #(
  parameter int REF_INTERVAL = 1562
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flag_init_i,
  output logic tick_o
);

  localparam int CNT_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

  logic [CNT_W-1:0] count_q, count_d;
  logic             atEnd;

  assign atEnd = (count_q == CNT_W'(REF_INTERVAL - 1));

  // Tick is gated by the enable so a frozen counter parked on the terminal
  // value does not emit a tick every cycle.
  assign tick_o = flag_init_i && atEnd;

  always_comb begin
    count_d = count_q;
    if (flag_init_i) begin
      count_d = atEnd ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sdram_aref_ctrl.sv
// ---------------------------------------------------------------------------
// sdram_aref_ctrl
//   SDRAM auto-refresh controller. Accumulates refresh debt from the interval
//   timer, requests the command bus while debt is outstanding and, once
//   granted, issues PRECHARGE-ALL followed by REF_BURST AUTO REFRESH commands
//   with tRP / tRFC spacing, then pulses ack and retires one unit of debt.
//   Ports:
//     S_CLK      system clock
//     RST        synchronous reset, active-high
//     flag_init  init complete; enables the interval timer
//     bus        sdram_aref_ctrl_if.master (req/en/ack/cmd/addr/debt/ovf)
//   Optional: define SDRAM_AREF_URGENT_EN to add bus.aref_urgent, which is
//   high while debt >= MAX_DEBT-1.
// ---------------------------------------------------------------------------
module sdram_aref_ctrl
  import sdram_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int REF_INTERVAL = 1562,
  parameter int REF_BURST    = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 7,
  parameter int MAX_DEBT     = 8
) (
  input  logic               S_CLK,
  input  logic               RST,
  input  logic               flag_init,
  sdram_aref_ctrl_if.master  bus
);

  localparam int DEBT_W  = $clog2(MAX_DEBT + 1);
  localparam int BURST_W = $clog2(REF_BURST + 1);
  localparam int WAIT_W  = $clog2(max_int(T_RP, T_RFC) + 1);

  // Wait counters count down to zero; entering the wait state one cycle after
  // the command means the load value is the interval minus two.
  localparam int RP_LOAD  = (T_RP  >= 2) ? T_RP  - 2 : 0;
  localparam int RFC_LOAD = (T_RFC >= 2) ? T_RFC - 2 : 0;

  localparam logic [ADDR_W-1:0] PREC_ADDR = ADDR_W'(1) << A10_BIT;

  aref_state_e        state_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [BURST_W-1:0] burst_q;
  logic [BURST_W-1:0] burstInc;
  logic [CMD_W-1:0]   cmd_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               ack_q;

  logic [DEBT_W-1:0]  debt_q, debt_d;
  logic               ovf_q, ovf_d;
  logic               req_q;

  logic               tick;
  logic               seqDone;

  sdram_aref_timer #(
    .REF_INTERVAL (REF_INTERVAL)
  ) u_timer (
    .clk_i       (S_CLK),
    .rst_i       (RST),
    .flag_init_i (flag_init),
    .tick_o      (tick)
  );

  assign burstInc = burst_q + BURST_W'(1);
  assign seqDone  = (state_q == ST_DONE);

  // Debt bookkeeping: a tick adds one, the ack cycle retires one, and both
  // together cancel. A tick that finds the counter saturated is lost and
  // latches the overflow flag instead.
  always_comb begin
    debt_d = debt_q;
    ovf_d  = ovf_q;
    if (tick && !seqDone) begin
      if (debt_q == DEBT_W'(MAX_DEBT)) begin
        ovf_d = 1'b1;
      end else begin
        debt_d = debt_q + DEBT_W'(1);
      end
    end else if (!tick && seqDone) begin
      debt_d = debt_q - DEBT_W'(1);
    end
  end

  // Request is registered from the next debt so it moves in the same cycle
  // as the debt output itself.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      debt_q <= '0;
      ovf_q  <= 1'b0;
      req_q  <= 1'b0;
    end else begin
      debt_q <= debt_d;
      ovf_q  <= ovf_d;
      req_q  <= (debt_d != '0);
    end
  end

  // Sequencer. Command, address and ack are registered alongside the state,
  // so each output appears in the same cycle as the state that owns it.
  // Outputs default back to NOP / 0 / 0 every cycle.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      burst_q <= '0;
      cmd_q   <= NOP;
      addr_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      cmd_q  <= NOP;
      addr_q <= '0;
      ack_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.aref_en && (debt_q != '0)) begin
            state_q <= ST_PRECH;
            cmd_q   <= PREC;
            addr_q  <= PREC_ADDR;
            burst_q <= '0;
          end
        end
        ST_PRECH: begin
          if (T_RP == 1) begin
            state_q <= ST_REF;
            cmd_q   <= AREF;
          end else begin
            state_q <= ST_WAIT_RP;
            wait_q  <= WAIT_W'(RP_LOAD);
          end
        end
        ST_WAIT_RP: begin
          if (wait_q == '0) begin
            state_q <= ST_REF;
            cmd_q   <= AREF;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_REF: begin
          burst_q <= burstInc;
          if (T_RFC == 1) begin
            if (burstInc < BURST_W'(REF_BURST)) begin
              state_q <= ST_REF;
              cmd_q   <= AREF;
            end else begin
              state_q <= ST_DONE;
              ack_q   <= 1'b1;
            end
          end else begin
            state_q <= ST_WAIT_RFC;
            wait_q  <= WAIT_W'(RFC_LOAD);
          end
        end
        ST_WAIT_RFC: begin
          if (wait_q == '0) begin
            if (burst_q < BURST_W'(REF_BURST)) begin
              state_q <= ST_REF;
              cmd_q   <= AREF;
            end else begin
              state_q <= ST_DONE;
              ack_q   <= 1'b1;
            end
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.aref_req  = req_q;
  assign bus.aref_ack  = ack_q;
  assign bus.aref_cmd  = cmd_q;
  assign bus.aref_addr = addr_q;
  assign bus.aref_debt = debt_q;
  assign bus.aref_ovf  = ovf_q;

`ifdef SDRAM_AREF_URGENT_EN
  logic urgent_q;

  // Lets the arbiter pre-empt read/write traffic before debt saturates.
  always_ff @(posedge S_CLK) begin
    if (RST) begin
      urgent_q <= 1'b0;
    end else begin
      urgent_q <= (debt_d >= DEBT_W'(MAX_DEBT - 1));
    end
  end

  assign bus.aref_urgent = urgent_q;
`endif

endmodule

// File: doc/sdram_aref_ctrl.md
Name: sdram_aref_ctrl

Overview:
Parametrised SDRAM auto-refresh controller. It counts refresh intervals once initialisation completes and tracks outstanding refreshes as a debt counter. It requests the command bus from the SDRAM arbiter, and on grant issues PRECHARGE-ALL followed by a configurable burst of AUTO REFRESH commands, honouring tRP and tRFC. It sits beside the init, read and write sub-controllers and drives the shared 5-bit command bus and the address bus through the arbiter mux.

Parameters:
ADDR_W, 12, SDRAM address width; must be ≥11 because A10 selects precharge-all.
REF_INTERVAL, 1562, S_CLK cycles per refresh tick (64 ms / 4096 rows at 100 MHz).
REF_BURST, 2, AUTO REFRESH commands issued per granted sequence (1..8).
T_RP, 2, cycles from PRECHARGE to the first AUTO REFRESH (≥1).
T_RFC, 7, cycles between consecutive AUTO REFRESH commands, and from the last one to ack (≥1).
MAX_DEBT, 8, saturation value of the pending-refresh counter (≥1).

Ports:
S_CLK  in  1  system clock.
RST  in  1  synchronous reset, active-high.
flag_init  in  1  init complete; the interval counter runs only while this is high.
aref_req  out  1  level request to the arbiter; high while debt > 0.
aref_en  in  1  grant from the arbiter; sampled only in IDLE.
aref_ack  out  1  single-cycle pulse at sequence completion.
aref_cmd  out  5  {CKE,CS_N,RAS_N,CAS_N,WE_N}.
aref_addr  out  ADDR_W  address bus.
aref_debt  out  $clog2(MAX_DEBT+1)  pending refresh count.
aref_ovf  out  1  sticky flag; set when a tick arrives while debt == MAX_DEBT.

Behaviour:
- Shared package constants: NOP=5'b10111, PREC=5'b10010, AREF=5'b10001.
- Reset values (sync, RST=1): aref_req=0, aref_ack=0, aref_cmd=NOP, aref_addr=0, aref_debt=0, aref_ovf=0, interval counter=0, FSM=IDLE. Reset mid-sequence aborts immediately; NOP appears on the next edge.
- Interval counter: counts 0..REF_INTERVAL-1 while flag_init=1 and holds otherwise. tick=1 for one cycle when count==REF_INTERVAL-1, then wraps to 0.
- Debt:
  - tick → +1.
  - Sequence completion (ack cycle) → −1.
  - Both in the same cycle → debt unchanged.
  - Tick at MAX_DEBT without completion → debt stays at MAX_DEBT and aref_ovf is set. aref_ovf clears only on reset.
- aref_req is a registered output: aref_req = (next debt != 0).
- All outputs are registered.
- FSM states: IDLE, PRECH, WAIT_RP, REF, WAIT_RFC, DONE.
  - IDLE: cmd=NOP, addr=0. If aref_en && debt>0 → PRECH. If aref_en is high with debt==0, it is ignored.
  - PRECH (one cycle, call it c0): cmd=PREC, addr A10=1, all other bits 0 → WAIT_RP.
  - WAIT_RP: cmd=NOP, addr=0. First AREF is issued at cycle c0+T_RP → REF.
  - REF (one cycle): cmd=AREF, addr=0; the burst counter increments → WAIT_RFC.
  - WAIT_RFC: NOP for T_RFC-1 cycles. Then REF again if burst count < REF_BURST, otherwise DONE.
  - DONE (one cycle): cmd=NOP, aref_ack=1, debt decrements → IDLE.
- Timing:
  - Last AREF at cycle cL; ack at cL+T_RFC.
  - With defaults: PREC c0, AREF c2, AREF c9, ack c16.
- aref_en is don't-care outside IDLE. Once started, a sequence always runs to completion; the arbiter must keep the bus granted until ack.
- flag_init falling mid-sequence does not abort the sequence; it only freezes the interval counter.

Optional Feature:
SDRAM_AREF_URGENT_EN
- With the macro defined: an extra output port aref_urgent (1 bit) is registered high when debt ≥ MAX_DEBT-1 and low otherwise. The arbiter uses it to pre-empt read/write bursts. Reset value 0.
- Without the macro: the port is absent and no logic is generated.

Decomposition:
- Package sdram_pkg: command localparams NOP/PREC/AREF/ACT/RD/WR/MRS, the FSM state enum, and an A10_BIT index constant.
- One sub-module, sdram_aref_timer: the REF_INTERVAL interval counter with flag_init gating and tick output.
- The FSM and debt logic stay in the top module.

Test Plan:
- Reset then flag_init=1, aref_en=0 for 3200 cycles → ticks at cycles 1561 and 3123; aref_debt reaches 2; aref_req rises the cycle after the first tick; cmd stays NOP.
- debt=1, pulse aref_en for one cycle in IDLE (defaults) → PREC with addr=12'h400 at c0, AREF at c2 and c9, NOP elsewhere; aref_ack high only at c16; debt becomes 0; aref_req low at c17.
- Completion coinciding with a tick → debt unchanged (1→1) and aref_req stays high.
- Hold aref_en=0 for 9 ticks with MAX_DEBT=8 → debt saturates at 8 and aref_ovf=1; after one sequence, debt=7 and ovf remains 1.
- Assert RST for one cycle at c5 of a sequence → next cycle shows cmd=NOP, ack=0, debt=0, FSM in IDLE; no AREF at c9.
- REF_BURST=1, T_RP=3, T_RFC=5 → PREC c0, AREF c3, ack c8. With SDRAM_AREF_URGENT_EN defined, aref_urgent rises when debt hits 7.
